// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM request arbiter and its 16-bit bus-core interface.
package sdram_pkg;

   localparam int SDRAM_ADDR_W = 23;
   localparam int SDRAM_DATA_W = 16;
   localparam int PORT_IDX_W   = 2;   // enough for up to 4 requesters

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_GAP     = 2'd2,
      S_REFRESH = 2'd3
   } state_t;

   function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [3:0] oh);
      logic [PORT_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) idx = PORT_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts at the port after the last grant.
module rr_pick
   import sdram_pkg::*;
#(
   parameter int NUM_PORTS = 3
) (
   input  logic [NUM_PORTS-1:0]  req,
   input  logic [PORT_IDX_W-1:0] last,
   output logic [NUM_PORTS-1:0]  grant
);

   always_comb begin
      logic                  found;
      logic [PORT_IDX_W-1:0] idx;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = PORT_IDX_W'((int'(last) + i) % NUM_PORTS);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one 16-bit SDRAM bus core, with a GAP cycle between
// transfers, on-demand refresh (realign) and a watchdog on sdram_finished.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int TIMEOUT   = 1023
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst,
   input  logic [NUM_PORTS-1:0]                      req_valid,
   input  logic [NUM_PORTS-1:0]                      req_write,
   input  logic [NUM_PORTS-1:0][SDRAM_ADDR_W-1:0]    req_addr,
   input  logic [NUM_PORTS-1:0][SDRAM_DATA_W-1:0]    req_wdata,
   output logic [NUM_PORTS-1:0]                      req_ack,
   output logic                                      req_err,
   output logic [SDRAM_DATA_W-1:0]                   req_rdata,
   input  logic                                      realign,
   output logic [SDRAM_ADDR_W-1:0]                   sdram_addr,
   output logic                                      sdram_read,
   output logic                                      sdram_write,
   output logic [SDRAM_DATA_W-1:0]                   sdram_writedata,
   output logic                                      sdram_refresh,
   input  logic [SDRAM_DATA_W-1:0]                   sdram_readdata,
   input  logic                                      sdram_finished,
   output state_t                                    fsm_state
);

   localparam int              WD_W   = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   state_t                  state, state_n;
   logic [PORT_IDX_W-1:0]   gnt, gnt_n;
   logic [NUM_PORTS-1:0]    pick;
   logic [WD_W-1:0]         wdog;
   logic                    done, timed_out;
   logic                    rd_n, wr_n, ref_n;
   logic [SDRAM_ADDR_W-1:0] addr_n;
   logic [SDRAM_DATA_W-1:0] wdata_n;

   rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req   (req_valid),
      .last  (gnt),
      .grant (pick)
   );

   // Completion is seen in the same cycle as sdram_finished so the requester can
   // capture req_rdata straight off the bus core's read data.
   assign done      = (state == S_ISSUE) && (sdram_finished || (wdog == WD_MAX));
   assign timed_out = (state == S_ISSUE) && !sdram_finished && (wdog == WD_MAX);

   assign req_ack   = done ? (NUM_PORTS'(1) << gnt) : '0;
   assign req_err   = timed_out;
   assign req_rdata = done ? sdram_readdata : '0;
   assign fsm_state = state;

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      rd_n    = 1'b0;
      wr_n    = 1'b0;
      ref_n   = 1'b0;
      addr_n  = sdram_addr;
      wdata_n = sdram_writedata;
      case (state)
         S_IDLE: begin
            if (realign) begin
               state_n = S_REFRESH;
               ref_n   = 1'b1;
            end else if (|req_valid) begin
               gnt_n   = onehot_to_idx(4'(pick));
               addr_n  = req_addr[gnt_n];
               wdata_n = req_wdata[gnt_n];
               wr_n    = req_write[gnt_n];
               rd_n    = !req_write[gnt_n];
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (done) begin
               state_n = S_GAP;
            end else begin
               rd_n = sdram_read;
               wr_n = sdram_write;
            end
         end
         S_GAP:     state_n = S_IDLE;
         S_REFRESH: state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state           <= S_IDLE;
         gnt             <= PORT_IDX_W'(NUM_PORTS - 1);
         wdog            <= '0;
         sdram_read      <= 1'b0;
         sdram_write     <= 1'b0;
         sdram_refresh   <= 1'b0;
         sdram_addr      <= '0;
         sdram_writedata <= '0;
      end else begin
         state           <= state_n;
         gnt             <= gnt_n;
         sdram_read      <= rd_n;
         sdram_write     <= wr_n;
         sdram_refresh   <= ref_n;
         sdram_addr      <= addr_n;
         sdram_writedata <= wdata_n;
         if ((state == S_ISSUE) && !done) wdog <= wdog + 1'b1;
         else                             wdog <= '0;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: the bench plays the bus core and the requesters.
module tb_sdram_arbiter;
   import sdram_pkg::*;

   localparam int NP = 3;
   localparam int TO = 15;

   logic                 clk, rst;
   logic [NP-1:0]        req_valid, req_write, req_ack;
   logic [NP-1:0][22:0]  req_addr;
   logic [NP-1:0][15:0]  req_wdata;
   logic                 req_err, realign;
   logic [15:0]          req_rdata, sdram_writedata, sdram_readdata;
   logic [22:0]          sdram_addr;
   logic                 sdram_read, sdram_write, sdram_refresh, sdram_finished;
   state_t               fsm_state;

   int n_vec = 0;
   int n_err = 0;

   sdram_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .req_valid       (req_valid),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_ack         (req_ack),
      .req_err         (req_err),
      .req_rdata       (req_rdata),
      .realign         (realign),
      .sdram_addr      (sdram_addr),
      .sdram_read      (sdram_read),
      .sdram_write     (sdram_write),
      .sdram_writedata (sdram_writedata),
      .sdram_refresh   (sdram_refresh),
      .sdram_readdata  (sdram_readdata),
      .sdram_finished  (sdram_finished),
      .fsm_state       (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bus-core model for one transfer. lat = cycles of strobe before sdram_finished;
   // lat = 0 means never finish, so the watchdog must fire in ISSUE cycle TO+1.
   task automatic serve(input int lat, input logic [15:0] rd, input int port, input logic wr,
                        input logic [22:0] addr, input logic [15:0] wd, output int waited);
      logic [NP-1:0] oh;
      logic          got;
      oh     = NP'(1) << port;
      got    = 1'b0;
      waited = 0;
      while (!(sdram_read || sdram_write) && waited < 20) begin
         tick();
         waited++;
      end
      chk("strobe_up", 32'(waited < 20), 32'd1);
      for (int n = 1; n <= 40; n++) begin
         chk("read_strobe", 32'(sdram_read), 32'(!wr));
         chk("write_strobe", 32'(sdram_write), 32'(wr));
         if (n == 1) begin
            chk("bus_addr", 32'(sdram_addr), 32'(addr));
            if (wr) chk("bus_wdata", 32'(sdram_writedata), 32'(wd));
         end
         if (lat != 0 && n == lat) begin
            sdram_finished = 1'b1;
            sdram_readdata = rd;
            #1;
            chk("ack", 32'(req_ack), 32'(oh));
            chk("err_ok", 32'(req_err), 32'd0);
            if (!wr) chk("rdata", 32'(req_rdata), 32'(rd));
            got = 1'b1;
            break;
         end
         if (lat == 0 && n == TO + 1) begin
            #1;
            chk("ack_timeout", 32'(req_ack), 32'(oh));
            chk("err_timeout", 32'(req_err), 32'd1);
            got = 1'b1;
            break;
         end
         chk("ack_early", 32'(req_ack), 32'd0);
         tick();
      end
      chk("ack_seen", 32'(got), 32'd1);
      tick();
      sdram_finished = 1'b0;
      sdram_readdata = 16'h0;
      #1;
      chk("gap_read", 32'(sdram_read), 32'd0);
      chk("gap_write", 32'(sdram_write), 32'd0);
      chk("gap_ack", 32'(req_ack), 32'd0);
      chk("gap_state", 32'(fsm_state), 32'(S_GAP));
   endtask

   initial begin
      int w;
      int lats[6];
      lats = '{1, 3, 2, 1, 2, 3};
      rst = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      realign = 1'b0; sdram_readdata = 16'h0; sdram_finished = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
      chk("rst_ack", 32'(req_ack), 32'd0);
      chk("rst_err", 32'(req_err), 32'd0);
      chk("rst_rdata", 32'(req_rdata), 32'd0);
      chk("rst_read", 32'(sdram_read), 32'd0);
      chk("rst_write", 32'(sdram_write), 32'd0);
      chk("rst_refresh", 32'(sdram_refresh), 32'd0);
      chk("rst_addr", 32'(sdram_addr), 32'd0);
      chk("rst_wdata", 32'(sdram_writedata), 32'd0);
      rst = 1'b0;

      // single read from port 1, finishes after 4 cycles
      req_addr[1] = 23'h000010; req_write[1] = 1'b0; req_valid[1] = 1'b1;
      serve(4, 16'hBEEF, 1, 1'b0, 23'h000010, 16'h0, w);
      req_valid[1] = 1'b0;
      tick();
      chk("idle_after_read", 32'(fsm_state), 32'(S_IDLE));

      // write from port 2 at the top address
      req_addr[2] = 23'h7FFFFF; req_wdata[2] = 16'h1234; req_write[2] = 1'b1; req_valid[2] = 1'b1;
      serve(2, 16'h0, 2, 1'b1, 23'h7FFFFF, 16'h1234, w);
      req_valid[2] = 1'b0; req_write[2] = 1'b0;
      tick();

      // sdram_finished while idle must not produce an ack
      sdram_finished = 1'b1; sdram_readdata = 16'hDEAD;
      #1;
      chk("stray_fin_ack", 32'(req_ack), 32'd0);
      chk("stray_fin_rdata", 32'(req_rdata), 32'd0);
      tick();
      chk("stray_fin_state", 32'(fsm_state), 32'(S_IDLE));
      sdram_finished = 1'b0; sdram_readdata = 16'h0;

      // all ports request continuously from reset: 0,1,2,0,1,2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int p = 0; p < NP; p++) req_addr[p] = 23'(23'h100 + p);
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         serve(lats[k], 16'(16'hA000 + k), k % 3, 1'b0, 23'(23'h100 + (k % 3)), 16'h0, w);
         chk("turnaround", 32'(w), (k == 0) ? 32'd1 : 32'd2);
      end
      req_valid = '0;
      tick();

      // realign and port 0 arrive together: refresh first
      realign = 1'b1; req_valid[0] = 1'b1;
      tick();
      chk("refresh_pulse", 32'(sdram_refresh), 32'd1);
      chk("refresh_no_read", 32'(sdram_read), 32'd0);
      chk("refresh_state", 32'(fsm_state), 32'(S_REFRESH));
      realign = 1'b0;
      tick();
      chk("refresh_one_cycle", 32'(sdram_refresh), 32'd0);
      chk("refresh_back_idle", 32'(fsm_state), 32'(S_IDLE));
      serve(1, 16'h5555, 0, 1'b0, 23'h100, 16'h0, w);
      chk("after_refresh_wait", 32'(w), 32'd1);
      req_valid[0] = 1'b0;
      tick();

      // watchdog: port 1 never finishes, then port 2 is served
      req_valid[1] = 1'b1; req_valid[2] = 1'b1;
      serve(0, 16'h0, 1, 1'b0, 23'h101, 16'h0, w);
      req_valid[1] = 1'b0;
      serve(2, 16'h7777, 2, 1'b0, 23'h102, 16'h0, w);
      chk("after_timeout_wait", 32'(w), 32'd2);
      req_valid[2] = 1'b0;
      tick();

      // reset two cycles into ISSUE
      req_valid[1] = 1'b1;
      tick();
      chk("abort_c1_read", 32'(sdram_read), 32'd1);
      tick();
      chk("abort_c2_read", 32'(sdram_read), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_read_drop", 32'(sdram_read), 32'd0);
      chk("abort_ack", 32'(req_ack), 32'd0);
      chk("abort_state", 32'(fsm_state), 32'(S_IDLE));
      tick();
      chk("abort_ack_held", 32'(req_ack), 32'd0);
      rst = 1'b0;
      req_valid = 3'b011;
      serve(1, 16'h0101, 0, 1'b0, 23'h100, 16'h0, w);
      req_valid[0] = 1'b0;
      serve(1, 16'h0202, 1, 1'b0, 23'h101, 16'h0, w);
      req_valid = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
